instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: i_reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: i_start  in  1  begin a load session; i_base_addr  in  8  first write address; i_count  in  9  words to write (0..256).
REQ-004 SHALL have: i_valid  in  1  instruction fields valid; o_ready  out  1  encoder accepts fields.
REQ-005 SHALL have: i_opcode  in  8; i_rd  in  4  write reg; i_ra  in  4  source reg 1; i_rb  in  4  source reg 2; i_imm  in  16  immediate.
REQ-006 SHALL have: o_mem_we  out  1  write strobe; o_mem_addr  out  8; o_mem_data  out  32  encoded word; i_mem_ready  in  1  memory accepts write.
REQ-007 SHALL have: o_busy  out  1  session active; o_done  out  1  one-cycle session-complete pulse; o_err  out  1  sticky illegal-opcode flag (CHECK_EN only, else 0).

Function
REQ-008 Encoding SHALL be: [31:24]=opcode; all unlisted bits 0.
REQ-009 NOP(0): remaining bits 0; LDA(1): [23:20]=i_rd, [15:0]=i_imm; STA(2): [23:20]=i_ra, [15:0]=i_imm; ADD(3)/SUB(4): [23:20]=i_rd, [7:4]=i_ra, [3:0]=i_rb.
REQ-010 FSM states IDLE, RUN, DRAIN, DONE.
REQ-011 IDLE: i_start=1 SHALL latch addr<=i_base_addr, remaining<=i_count; go RUN, or DONE if i_count=0.
REQ-012 RUN: o_ready = (remaining_to_accept>0) && (!out_valid || i_mem_ready); transfer occurs when i_valid && o_ready.
REQ-013 Accepted word SHALL appear on o_mem_data/o_mem_addr with o_mem_we=1 the next cycle (latency 1), held stable until i_mem_ready=1.
REQ-014 Write completes on o_mem_we && i_mem_ready; address SHALL then increment modulo 256 (0xFF wraps to 0x00).
REQ-015 Simultaneous write-complete and new accept in the same cycle SHALL sustain one word per cycle.
REQ-016 After last accept, FSM SHALL enter DRAIN; on last write completion go DONE; DONE asserts o_done one cycle, then IDLE.
REQ-017 i_start SHALL be ignored outside IDLE; i_valid SHALL be ignored outside RUN.
REQ-018 o_busy=1 in RUN and DRAIN.

Reset
REQ-019 Asynchronous assertion SHALL force IDLE, o_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_busy=0, o_done=0, o_err=0, counters 0.
REQ-020 Reset mid-session SHALL abandon any pending write without further strobes; deassertion takes effect at next i_clk edge.

Configuration
REQ-021 Macro INSTR_ENCODER_CHECK_EN defined: opcode >4 SHALL be accepted but not written (counts against i_count, address not incremented), o_err set until reset or next i_start.
REQ-022 Undefined: opcode >4 SHALL be encoded as [31:24]=opcode, rest 0, and written normally; o_err tied 0.

Structure
REQ-023 Opcode constants (NOP, LDA, STA, ADD, SUB), field bit positions and FSM state type SHALL live in a shared cpu package used also by the decoder.
REQ-024 Field-to-word encoding SHALL be a purely combinational sub-module instr_pack; instr_encoder holds FSM, counters, output register.

Verification
REQ-025 start base=0x10 count=1; ADD rd=2 ra=3 rb=4 -> one write addr 0x10 data 0x03200034, o_done next cycle after write.
REQ-026 count=3, LDA rd=1 imm=0x1234, STA ra=5 imm=0x00FF, SUB rd=F ra=A rb=B, i_mem_ready=1 -> data 0x01101234, 0x025000FF, 0x04F000AB at consecutive addrs, back-to-back cycles.
REQ-027 base=0xFE count=3, i_mem_ready held 0 for 4 cycles then 1 -> word held stable, o_ready=0 while stalled, addrs 0xFE,0xFF,0x00.
REQ-028 start count=0 -> no o_mem_we, o_done pulse, back to IDLE; i_start during RUN -> ignored.
REQ-029 Reset asserted with pending write -> o_mem_we=0 immediately, all outputs at reset values; CHECK_EN: opcode 0x07 -> no write, o_err=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and the
// load-session FSM state type, used by the instruction encoder and the decoder.
package cpu_pkg;

    localparam int OPC_W = 8;
    localparam int REG_W = 4;
    localparam int IMM_W = 16;
    localparam int WORD_W = 32;

    localparam logic [OPC_W-1:0] OP_NOP = 8'd0;
    localparam logic [OPC_W-1:0] OP_LDA = 8'd1;
    localparam logic [OPC_W-1:0] OP_STA = 8'd2;
    localparam logic [OPC_W-1:0] OP_ADD = 8'd3;
    localparam logic [OPC_W-1:0] OP_SUB = 8'd4;

    // Bit positions inside the 32-bit instruction word.
    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 20;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        return op <= OP_SUB;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Purely combinational field-to-word packer. Opcode always lands in [31:24];
// operand fields depend on the opcode, every other bit is zero.
module instr_pack
    import cpu_pkg::*;
(
    input  instr_fields_t       fields_i,
    output logic [WORD_W-1:0]   word_o
);

    always_comb begin
        word_o = '0;
        word_o[OPC_LSB +: OPC_W] = fields_i.opcode;
        case (fields_i.opcode)
            OP_LDA: begin
                word_o[RD_LSB +: REG_W]  = fields_i.rd;
                word_o[IMM_LSB +: IMM_W] = fields_i.imm;
            end
            // STA carries its source register in the destination slot.
            OP_STA: begin
                word_o[RD_LSB +: REG_W]  = fields_i.ra;
                word_o[IMM_LSB +: IMM_W] = fields_i.imm;
            end
            OP_ADD, OP_SUB: begin
                word_o[RD_LSB +: REG_W] = fields_i.rd;
                word_o[RA_LSB +: REG_W] = fields_i.ra;
                word_o[RB_LSB +: REG_W] = fields_i.rb;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction loader: accepts instruction fields over a valid/ready handshake and
// writes packed words to consecutive memory addresses. INSTR_ENCODER_CHECK_EN drops illegal opcodes.
//
// Handshake: a field transfer happens on a rising edge where i_valid && o_ready;
// a memory write completes on a rising edge where o_mem_we && i_mem_ready. The
// output word is held stable while o_mem_we=1 and i_mem_ready=0.
module instr_encoder
    import cpu_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_start,
    input  logic [7:0]          i_base_addr,
    input  logic [8:0]          i_count,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [OPC_W-1:0]    i_opcode,
    input  logic [REG_W-1:0]    i_rd,
    input  logic [REG_W-1:0]    i_ra,
    input  logic [REG_W-1:0]    i_rb,
    input  logic [IMM_W-1:0]    i_imm,
    output logic                o_mem_we,
    output logic [7:0]          o_mem_addr,
    output logic [WORD_W-1:0]   o_mem_data,
    input  logic                i_mem_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [1:0]          o_state_dbg
);

    enc_state_t          state_q;
    logic [7:0]          addr_q;
    logic [8:0]          accept_rem_q;
    logic                we_q;
    logic [WORD_W-1:0]   data_q;

    instr_fields_t       fields;
    logic [WORD_W-1:0]   packed_word;
    logic                accept;
    logic                wr_done;
    logic                legal;

    assign fields = '{opcode: i_opcode, rd: i_rd, ra: i_ra, rb: i_rb, imm: i_imm};

    instr_pack u_pack (
        .fields_i (fields),
        .word_o   (packed_word)
    );

    // Ready folds in i_mem_ready so a completing write and a new accept share a cycle.
    assign o_ready = (state_q == ST_RUN) && (accept_rem_q != 9'd0) && (!we_q || i_mem_ready);
    assign accept  = i_valid && o_ready;
    assign wr_done = we_q && i_mem_ready;

`ifdef INSTR_ENCODER_CHECK_EN
    logic err_q;
    assign legal = is_legal_op(i_opcode);
    assign o_err = err_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && i_start) begin
            err_q <= 1'b0;
        end else if (accept && !legal) begin
            err_q <= 1'b1;
        end
    end
`else
    assign legal = 1'b1;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 8'd0;
            accept_rem_q <= 9'd0;
            we_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            if (wr_done) begin
                addr_q <= addr_q + 8'd1;
                we_q   <= 1'b0;
            end
            if (accept) begin
                accept_rem_q <= accept_rem_q - 9'd1;
                if (legal) begin
                    we_q   <= 1'b1;
                    data_q <= packed_word;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_q       <= i_base_addr;
                        accept_rem_q <= i_count;
                        state_q      <= (i_count == 9'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && accept_rem_q == 9'd1) begin
                        state_q <= ST_DRAIN;
                    end
                end
                // A dropped last word leaves nothing pending, so DRAIN can exit at once.
                ST_DRAIN: begin
                    if (!we_q || wr_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_data  = data_q;
    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);
    assign o_state_dbg = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: randomized and directed load sessions,
// expected writes computed from the instruction format rules.
module tb_instr_encoder;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_start;
    logic [7:0]  i_base_addr;
    logic [8:0]  i_count;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_opcode;
    logic [3:0]  i_rd, i_ra, i_rb;
    logic [15:0] i_imm;
    logic        o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_data;
    logic        i_mem_ready;
    logic        o_busy, o_done, o_err;
    logic [1:0]  st_dbg;

    always #5 i_clk = ~i_clk;

    instr_encoder dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_opcode    (i_opcode),
        .i_rd        (i_rd),
        .i_ra        (i_ra),
        .i_rb        (i_rb),
        .i_imm       (i_imm),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .i_mem_ready (i_mem_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_state_dbg (st_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];
    logic        m_err;

    logic [7:0]  d_op[4];
    logic [3:0]  d_rd[4], d_ra[4], d_rb[4];
    logic [15:0] d_imm[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the instruction format table.
    function automatic logic [31:0] ref_word(input logic [7:0] op, input logic [3:0] rd,
                                             input logic [3:0] ra, input logic [3:0] rb,
                                             input logic [15:0] imm);
        int unsigned w;
        w = 32'(op) * 32'h0100_0000;
        case (op)
            8'd1:       w = w + 32'(rd) * 32'h0010_0000 + 32'(imm);
            8'd2:       w = w + 32'(ra) * 32'h0010_0000 + 32'(imm);
            8'd3, 8'd4: w = w + 32'(rd) * 32'h0010_0000 + 32'(ra) * 32'd16 + 32'(rb);
            default:    w = w;
        endcase
        return w;
    endfunction

    // Monitor: pops one expectation per completed write and checks stall behaviour.
    initial begin
        logic        held;
        logic [7:0]  h_addr;
        logic [31:0] h_data;
        logic [39:0] e;
        held = 1'b0;
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_reset_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_hold_we", 64'(o_mem_we), 64'd1);
                    check("stall_hold_addr", 64'(o_mem_addr), 64'(h_addr));
                    check("stall_hold_data", 64'(o_mem_data), 64'(h_data));
                end
                held = 1'b0;
                if (o_mem_we) begin
                    if (i_mem_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_write", 64'(o_mem_addr), 64'hFFFF);
                        end else begin
                            e = exp_q.pop_front();
                            check("write_addr", 64'(o_mem_addr), 64'(e[39:32]));
                            check("write_data", 64'(o_mem_data), 64'(e[31:0]));
                        end
                    end else begin
                        check("ready_low_in_stall", 64'(o_ready), 64'd0);
                        held   = 1'b1;
                        h_addr = o_mem_addr;
                        h_data = o_mem_data;
                    end
                end
            end
        end
    end

    task automatic run_session(input logic [7:0] base, input logic [8:0] cnt, input int rdy_pct,
                               input int vld_pct, input bit directed, input int stall_from,
                               input int stall_to, output int cycles);
        int         sent;
        logic [7:0] m_addr;
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = base; i_count = cnt; i_valid = 1'b0; i_mem_ready = 1'b1;
        m_addr = base; m_err = 1'b0; sent = 0;
        @(negedge i_clk);
        i_start = 1'b0;
        cycles = 1;
        while (!o_done && cycles < 3000) begin
            check("busy_in_session", 64'(o_busy), 64'd1);
            if (sent < int'(cnt)) i_valid = ($urandom_range(0, 99) < vld_pct);
            else                  i_valid = ($urandom_range(0, 3) == 0);
            if (directed && sent < 4) begin
                i_opcode = d_op[sent]; i_rd = d_rd[sent]; i_ra = d_ra[sent];
                i_rb = d_rb[sent]; i_imm = d_imm[sent];
            end else begin
                i_opcode = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 255))
                                                        : 8'($urandom_range(0, 4));
                i_rd = 4'($urandom); i_ra = 4'($urandom); i_rb = 4'($urandom);
                i_imm = 16'($urandom);
            end
            i_mem_ready = (cycles >= stall_from && cycles <= stall_to) ? 1'b0
                        : ($urandom_range(0, 99) < rdy_pct);
            i_start = ($urandom_range(0, 7) == 0);
            i_base_addr = 8'($urandom);
            i_count = 9'($urandom_range(0, 256));
            #1;
            if (i_valid && o_ready) begin
`ifdef INSTR_ENCODER_CHECK_EN
                if (i_opcode > 8'd4) begin
                    m_err = 1'b1;
                end else begin
                    exp_q.push_back({m_addr, ref_word(i_opcode, i_rd, i_ra, i_rb, i_imm)});
                    m_addr = m_addr + 8'd1;
                end
`else
                exp_q.push_back({m_addr, ref_word(i_opcode, i_rd, i_ra, i_rb, i_imm)});
                m_addr = m_addr + 8'd1;
`endif
                sent++;
            end
            @(negedge i_clk);
            cycles++;
        end
        i_valid = 1'b0; i_start = 1'b0; i_mem_ready = 1'b1;
        check("done_within_budget", 64'(cycles < 3000), 64'd1);
        check("accepted_count", 64'(sent), 64'(cnt));
        check("err_flag", 64'(o_err), 64'(m_err));
        check("writes_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge i_clk);
        check("done_one_cycle", 64'(o_done), 64'd0);
        check("busy_after_done", 64'(o_busy), 64'd0);
        check("idle_state", 64'(st_dbg), 64'd0);
    endtask

    task automatic idle_noise();
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_opcode = 8'($urandom_range(0, 4)); i_imm = 16'($urandom);
            i_mem_ready = 1'($urandom);
            #1;
            check("ready_low_idle", 64'(o_ready), 64'd0);
        end
        @(negedge i_clk);
        i_valid = 1'b0; i_mem_ready = 1'b1;
    endtask

    task automatic set_dir(input int k, input logic [7:0] op, input logic [3:0] rd,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [15:0] imm);
        d_op[k] = op; d_rd[k] = rd; d_ra[k] = ra; d_rb[k] = rb; d_imm[k] = imm;
    endtask

    initial begin
        int cyc;
        i_reset_n = 1'b0; i_start = 1'b0; i_base_addr = 8'd0; i_count = 9'd0; i_valid = 1'b0;
        i_opcode = 8'd0; i_rd = 4'd0; i_ra = 4'd0; i_rb = 4'd0; i_imm = 16'd0; i_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_dir(k, 8'd0, 4'd0, 4'd0, 4'd0, 16'd0);
        #2;
        check("rst_we", 64'(o_mem_we), 64'd0);
        check("rst_addr", 64'(o_mem_addr), 64'd0);
        check("rst_data", 64'(o_mem_data), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;

        // Single ADD, done pulse the cycle after the write.
        set_dir(0, 8'd3, 4'h2, 4'h3, 4'h4, 16'h0);
        run_session(8'h10, 9'd1, 100, 100, 1'b1, 0, -1, cyc);
        check("single_latency", 64'(cyc), 64'd3);

        // Back-to-back stream of three words.
        set_dir(0, 8'd1, 4'h1, 4'h0, 4'h0, 16'h1234);
        set_dir(1, 8'd2, 4'h0, 4'h5, 4'h0, 16'h00FF);
        set_dir(2, 8'd4, 4'hF, 4'hA, 4'hB, 16'h0);
        run_session(8'h40, 9'd3, 100, 100, 1'b1, 0, -1, cyc);
        check("stream_latency", 64'(cyc), 64'd5);

        // Memory stall of four cycles with address wrap.
        run_session(8'hFE, 9'd3, 100, 100, 1'b1, 2, 5, cyc);
        check("stall_latency", 64'(cyc), 64'd9);

        run_session(8'h33, 9'd0, 100, 100, 1'b0, 0, -1, cyc);
        check("zero_count_latency", 64'(cyc), 64'd1);
        idle_noise();

`ifdef INSTR_ENCODER_CHECK_EN
        set_dir(0, 8'h07, 4'h1, 4'h2, 4'h3, 16'h5555);
        set_dir(1, 8'd3, 4'h6, 4'h7, 4'h8, 16'h0);
        run_session(8'h20, 9'd2, 100, 100, 1'b1, 0, -1, cyc);
        check("illegal_err_set", 64'(o_err), 64'd1);
`endif

        for (int s = 0; s < 25; s++) begin
            run_session(8'($urandom), 9'($urandom_range(0, 24)), int'($urandom_range(40, 100)),
                        int'($urandom_range(40, 100)), 1'b0, 0, -1, cyc);
            if (s % 5 == 0) idle_noise();
        end
        run_session(8'($urandom), 9'd256, 70, 90, 1'b0, 0, -1, cyc);

        // Reset with a write pending.
        @(negedge i_clk);
        i_start = 1'b1; i_base_addr = 8'h80; i_count = 9'd4; i_mem_ready = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0; i_valid = 1'b1; i_opcode = 8'd1; i_rd = 4'h9; i_imm = 16'hBEEF;
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        check("pending_before_reset", 64'(o_mem_we), 64'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_we", 64'(o_mem_we), 64'd0);
        check("mid_rst_addr", 64'(o_mem_addr), 64'd0);
        check("mid_rst_data", 64'(o_mem_data), 64'd0);
        check("mid_rst_ready", 64'(o_ready), 64'd0);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_done", 64'(o_done), 64'd0);
        check("mid_rst_err", 64'(o_err), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1; i_mem_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        #1;
        check("post_rst_idle_busy", 64'(o_busy), 64'd0);
        run_session(8'h55, 9'd5, 80, 80, 1'b0, 0, -1, cyc);

        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
